// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency byte-addressed data memory with valid/ready request and response channels.
module dmem_responder #(
  parameter int unsigned MEM_DEPTH = 1048576,
  parameter logic [31:0] BASE_ADDR = 32'h01000000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0] size_q;
  logic we_q, err_q;
  logic [7:0] mem [MEM_DEPTH];
  // With LATENCY=1 the commit happens on the accept edge, so operate on the live inputs then.
  logic accept, commit, op_we, bad;
  logic [31:0] op_addr, op_wdata, off, word, mask, ld;
  logic [1:0] op_size;
  logic [2:0] nb;
  logic [32:0] end_off;
  logic [AW-1:0] idx;
  always_comb begin
    accept = state == IDLE && req_valid;
    commit = (accept && LATENCY == 1) || (state == WAIT && cnt == 4'd0);
    op_addr = accept ? req_addr : addr_q;
    op_wdata = accept ? req_wdata : wdata_q;
    op_size = accept ? req_size : size_q;
    op_we = accept ? req_we : we_q;
    off = op_addr - BASE_ADDR;
    nb = op_size == 2'd0 ? 3'd1 : op_size == 2'd1 ? 3'd2 : 3'd4;
    end_off = {1'b0, off} + {30'b0, nb};
    bad = op_size == 2'd3 || (op_size == 2'd1 && op_addr[0]) ||
          (op_size == 2'd2 && op_addr[1:0] != 2'd0) || end_off > 33'(MEM_DEPTH);
    idx = off[AW-1:0];
    word = {mem[idx + AW'(3)], mem[idx + AW'(2)], mem[idx + AW'(1)], mem[idx]};
    mask = op_size == 2'd0 ? 32'hFF : op_size == 2'd1 ? 32'hFFFF : 32'hFFFF_FFFF;
    ld = (bad || op_we) ? 32'd0 : word & mask;
  end
  always_ff @(posedge clock)
    if (!reset && commit && op_we && !bad)
      for (int k = 0; k < 4; k++)
        if (k < 32'(nb)) mem[idx + AW'(k)] <= op_wdata[8*k +: 8];
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      rdata_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q <= req_addr;
          we_q <= req_we;
          size_q <= req_size;
          wdata_q <= req_wdata;
          if (LATENCY == 1) begin
            state <= RESP;
            rdata_q <= ld;
            err_q <= bad;
          end else begin
            state <= WAIT;
            cnt <= 4'(LATENCY - 2);
          end
        end
        WAIT: if (cnt == 4'd0) begin
          state <= RESP;
          rdata_q <= ld;
          err_q <= bad;
        end else cnt <= cnt - 4'd1;
        RESP: if (rsp_ready) begin
          state <= IDLE;
          rdata_q <= 32'd0;
          err_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1048576, bytes of backing storage.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h01000000, first valid byte address.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request accept to rsp_valid; legal range 1..15.
REQ-004 SHALL have port clock  in  1  clock; all state updates on posedge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  in  1  initiator presents a request.
REQ-007 SHALL have port req_ready  out  1  responder can accept a request.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-010 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 SHALL have port req_wdata  in  32  store data, right-aligned (bits [7:0] for byte).
REQ-012 SHALL have port rsp_valid  out  1  response available.
REQ-013 SHALL have port rsp_ready  in  1  initiator accepts the response.
REQ-014 SHALL have port rsp_rdata  out  32  load data, right-aligned, zero-extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  out  1  request was rejected (see REQ-021).

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-017 SHALL accept a request in a cycle where req_valid && req_ready, latching addr, we, size, wdata; the request inputs are ignored in all other cycles.
REQ-018 SHALL transition IDLE->RESP on accept when LATENCY = 1; otherwise IDLE->WAIT with a down-counter loaded with LATENCY-2, and WAIT->RESP when the counter reads 0; rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-019 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready = 1, then transition to IDLE on that edge; req_ready reasserts in the following cycle (min. request-to-request spacing LATENCY+1 cycles).
REQ-020 SHALL store little-endian: byte lane k of a word = addr offset k; a half writes bytes addr and addr+1; a word writes addr..addr+3; untouched bytes are unchanged.
REQ-021 SHALL flag an error when size = 11, half with addr[0] = 1, word with addr[1:0] != 0, or any addressed byte outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH); errored requests SHALL NOT modify storage and SHALL return rsp_rdata = 0, rsp_err = 1.
REQ-022 SHALL commit a store to storage on the edge entering RESP, and sample load data on that same edge into the response register, so a load issued after a store response sees the stored value.
REQ-023 SHALL compute address offset as req_addr - BASE_ADDR in 32-bit unsigned arithmetic; addresses below BASE_ADDR wrap to large offsets and fail the range check.
REQ-024 SHALL drive rsp_err = 0 and rsp_rdata = 0 whenever rsp_valid = 0.

Reset
REQ-025 SHALL on reset force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready = 1 in the first cycle after reset deasserts.
REQ-026 SHALL abandon any in-flight request on reset; a store whose commit edge coincides with reset SHALL NOT be written.
REQ-027 SHALL leave storage contents unaffected by reset.

Verification
REQ-028 Word store 0xDEADBEEF @0x01000010, then word load @0x01000010 -> load rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid exactly 2 cycles after each accept (LATENCY=2).
REQ-029 After REQ-028, byte store 0xAA @0x01000011 then byte load @0x01000011 -> 0x000000AA; word load @0x01000010 -> 0xDEADAAEF.
REQ-030 Half load @0x01000011, word load @0x01000012, size 11 @0x01000010, word load @0x00FFFFFC -> each rsp_err 1, rsp_rdata 0; word store with size 11 leaves @0x01000010 unchanged.
REQ-031 Hold rsp_ready 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready 0; raise rsp_ready -> IDLE next cycle, req_ready 1.
REQ-032 Store 0x12345678 @0x01000020, assert reset for one cycle on the edge that would enter RESP -> no response, req_ready 1 after reset; subsequent word load @0x01000020 returns prior contents (0 if never written).
REQ-033 LATENCY=1 build: back-to-back loads with rsp_ready tied 1 -> rsp_valid one cycle after each accept, accepts every 2 cycles.
